cpu_fetch_seq: RTL and testbench

Fetch sequencer directly upstream of the CPU instruction-fetch bus stage. Owns the program counter, issues one single-cycle fetch request at a time (`pc_valid`/`pc`), captures the returned word (`instr_valid`/`instr`/`fetch_err`) into an output register, and presents it to decode with a valid/ready handshake. Handles control-flow redirects, including discarding a response still in flight when the redirect arrives. Strictly one outstanding fetch.

---
 rtl/cpu_fetch_pkg.sv | 20 ++
 rtl/cpu_fetch_seq.sv | 116 +++++++++++
 tb/tb_cpu_fetch_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_OK         = 2'd0,
    FETCH_BUS_ERR    = 2'd1,
    FETCH_MISALIGNED = 2'd2
  } fetch_cause_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/cpu_fetch_seq.sv
// rtl/cpu_fetch_seq.sv - single-outstanding instruction fetch sequencer with redirect and squash
module cpu_fetch_seq
  import cpu_fetch_pkg::*;
#(
  parameter int                   AddrWidth   = 32,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic                 pc_valid,
  output logic [AddrWidth-1:0] pc,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  input  logic                 fetch_err,
  input  logic                 redirect_valid,
  input  logic [AddrWidth-1:0] redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [AddrWidth-1:0] out_pc,
  output logic [1:0]           out_cause,
  output logic                 busy
);

  fetch_state_e         state, state_next;
  logic [AddrWidth-1:0] pc_q;
  logic [31:0]          out_instr_q;
  logic [AddrWidth-1:0] out_pc_q;
  fetch_cause_e         out_cause_q;

  logic misaligned;
  logic resp;
  logic handshake;
  logic load_out;
  logic [31:0]  load_instr;
  fetch_cause_e load_cause;

  assign misaligned = |pc_q[1:0];
  assign resp       = instr_valid | fetch_err;
  assign handshake  = (state == ST_HOLD) && !redirect_valid && out_ready;

  assign pc        = pc_q;
  assign pc_valid  = (state == ST_ISSUE) && !misaligned;
  assign busy      = (state == ST_WAIT) || (state == ST_DRAIN);
  assign out_valid = (state == ST_HOLD) && !redirect_valid;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_cause = out_cause_q;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (run) state_next = ST_ISSUE;
      ST_ISSUE: state_next = misaligned ? ST_HOLD : ST_WAIT;
      ST_WAIT:  if (resp) state_next = ST_HOLD;
      ST_DRAIN: if (resp) state_next = ST_ISSUE;
      ST_HOLD: begin
        if (out_ready) state_next = (out_cause_q == FETCH_OK) ? ST_ISSUE : ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase

    // A request strobed this cycle or still pending must be drained before the
    // redirect target is fetched; a misaligned ISSUE never strobed, so it can refetch directly.
    if (redirect_valid) begin
      case (state)
        ST_ISSUE: state_next = misaligned ? ST_ISSUE : ST_DRAIN;
        ST_WAIT,
        ST_DRAIN: state_next = resp ? ST_ISSUE : ST_DRAIN;
        default:  state_next = ST_ISSUE;
      endcase
    end
  end

  always_comb begin
    load_out   = 1'b0;
    load_instr = 32'h0;
    load_cause = FETCH_OK;
    if (!redirect_valid) begin
      if (state == ST_ISSUE && misaligned) begin
        load_out   = 1'b1;
        load_cause = FETCH_MISALIGNED;
      end else if (state == ST_WAIT && fetch_err) begin
        load_out   = 1'b1;
        load_cause = FETCH_BUS_ERR;
      end else if (state == ST_WAIT && instr_valid) begin
        load_out   = 1'b1;
        load_instr = instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc_q        <= ResetVector;
      out_instr_q <= 32'h0;
      out_pc_q    <= '0;
      out_cause_q <= FETCH_OK;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc_q <= redirect_pc;
      end else if (handshake && out_cause_q == FETCH_OK) begin
        pc_q <= pc_q + AddrWidth'(INSTR_BYTES);
      end
      if (load_out) begin
        out_instr_q <= load_instr;
        out_pc_q    <= pc_q;
        out_cause_q <= load_cause;
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// tb/tb_cpu_fetch_seq.sv - scoreboard bench for cpu_fetch_seq
module tb_cpu_fetch_seq;
  import cpu_fetch_pkg::*;

  localparam logic [31:0] RV = 32'hFFFF_FFFC;

  typedef struct {logic [31:0] pc; int cyc;} req_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc; logic [1:0] cause;} out_t;
  typedef struct {int lat; bit err; logic [31:0] data;} bus_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        pc_valid;
  logic [31:0] pc;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'hA5A5_A5A5;
  logic        fetch_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [1:0]  out_cause;
  logic        busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int hs_cnt = 0;
  bit stray_ok = 1'b0;

  req_t exp_req[$];
  out_t exp_out[$];
  bus_t bus_q[$];
  req_t mon_r;
  out_t mon_o;
  bus_t bus_e;

  cpu_fetch_seq #(.AddrWidth(32), .ResetVector(RV)) dut (
    .clk(clk), .reset(reset), .run(run), .pc_valid(pc_valid), .pc(pc),
    .instr_valid(instr_valid), .instr(instr), .fetch_err(fetch_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_cause(out_cause), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] p, input int c);
    req_t r;
    r.pc = p; r.cyc = c;
    exp_req.push_back(r);
  endtask

  task automatic push_out(input logic [31:0] i, input logic [31:0] p, input logic [1:0] c);
    out_t o;
    o.instr = i; o.pc = p; o.cause = c;
    exp_out.push_back(o);
  endtask

  task automatic push_bus(input int l, input bit e, input logic [31:0] d);
    bus_t b;
    b.lat = l; b.err = e; b.data = d;
    bus_q.push_back(b);
  endtask

  // Bus responder: acks each strobe after its scripted latency, regardless of squashes.
  initial begin
    forever begin
      @(negedge clk);
      if (pc_valid === 1'b1) begin
        if (bus_q.size() != 0) bus_e = bus_q.pop_front();
        else begin bus_e.lat = 1; bus_e.err = 1'b0; bus_e.data = 32'h0000_0013; end
        repeat (bus_e.lat) @(posedge clk);
        #1;
        instr_valid = !bus_e.err;
        fetch_err   = bus_e.err;
        instr       = bus_e.data;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        instr       = 32'hA5A5_A5A5;
      end
    end
  end

  // Monitor: fetch requests, presented outputs and response legality.
  always @(negedge clk) begin
    if (pc_valid === 1'b1) begin
      if (exp_req.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_req: got pc=%h want no request", pc);
      end else begin
        mon_r = exp_req.pop_front();
        chk("req_pc", pc, mon_r.pc);
        if (mon_r.cyc >= 0) chk("req_cycle", 32'(cyc - t0), 32'(mon_r.cyc));
      end
    end
    if (out_valid === 1'b1) begin
      if (exp_out.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got pc=%h instr=%h want no output", out_pc, out_instr);
      end else begin
        mon_o = exp_out[0];
        chk("out_instr", out_instr, mon_o.instr);
        chk("out_pc", out_pc, mon_o.pc);
        chk("out_cause", {30'h0, out_cause}, {30'h0, mon_o.cause});
        if (out_ready === 1'b1) begin
          exp_out.delete(0);
          hs_cnt++;
        end
      end
    end
    if ((instr_valid || fetch_err) && !stray_ok) begin
      chk1("resp_only_when_busy", busy, 1'b1);
      chk1("resp_not_in_issue", pc_valid, 1'b0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) return;
    end
    total++; bad++;
    $display("FAIL %s: got no out_valid want out_valid within 100 cycles", name);
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hs_cnt >= n) return;
    end
    total++; bad++;
    $display("FAIL wait_hs: got %0d handshakes want %0d", hs_cnt, n);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("quiet_pc_valid", pc_valid, 1'b0);
      chk1("quiet_busy", busy, 1'b0);
      chk1("quiet_out_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cycle();
    chk1("rst_pc_valid", pc_valid, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_cause", {30'h0, out_cause}, 32'h0);
    chk("rst_pc", pc, RV);
    reset = 1'b0;
    cycle();
    chk1("idle_no_req", pc_valid, 1'b0);

    // Zero-wait stream with wrap, back-pressure on 0x4, bus error on 0x8.
    push_bus(1, 1'b0, 32'h0000_0013);
    push_bus(1, 1'b0, 32'h0000_0013);
    push_bus(1, 1'b0, 32'h0000_0013);
    push_bus(2, 1'b1, 32'hDEAD_C0DE);
    push_req(RV, 1);
    push_req(32'h0, 4);
    push_req(32'h4, 7);
    push_req(32'h8, -1);
    push_out(32'h13, RV, 2'd0);
    push_out(32'h13, 32'h0, 2'd0);
    push_out(32'h13, 32'h4, 2'd0);
    push_out(32'h0, 32'h8, 2'd1);
    run = 1'b1;
    t0 = cyc;
    cycle();
    run = 1'b0;
    wait_hs(2);
    cycle();
    out_ready = 1'b0;
    wait_out_valid("hold_pc4");
    for (int i = 0; i < 5; i++) begin
      chk1("hold_valid", out_valid, 1'b1);
      chk("hold_pc", out_pc, 32'h4);
      chk("hold_instr", out_instr, 32'h13);
      chk1("hold_no_req", pc_valid, 1'b0);
      @(negedge clk);
    end
    cycle();
    out_ready = 1'b1;
    wait_hs(4);
    cycle();
    quiet(6);

    // Redirect to 0x40, then to 0x100 while 0x40 is outstanding; then 0x102 during ISSUE.
    push_bus(4, 1'b0, 32'hDEAD_BEEF);
    push_req(32'h40, -1);
    push_req(32'h100, -1);
    push_req(32'h104, -1);
    push_out(32'h13, 32'h100, 2'd0);
    push_out(32'h0, 32'h102, 2'd2);
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk1("wait_busy", busy, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    out_ready = 1'b0;
    cycle();
    redirect_valid = 1'b0;
    chk1("drain_busy", busy, 1'b1);
    wait_out_valid("hold_pc100");
    cycle();
    out_ready = 1'b1;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    out_ready = 1'b0;
    cycle();
    redirect_valid = 1'b0;
    wait_out_valid("misaligned");
    cycle();
    out_ready = 1'b1;
    wait_hs(6);
    cycle();
    quiet(3);

    // Reset while waiting on 0x200; the late ack must be ignored.
    push_bus(5, 1'b0, 32'h0000_0013);
    push_req(32'h200, -1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    chk1("wait200_busy", busy, 1'b1);
    cycle();
    reset = 1'b1;
    stray_ok = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("postrst_pc_valid", pc_valid, 1'b0);
      chk1("postrst_busy", busy, 1'b0);
      chk1("postrst_out_valid", out_valid, 1'b0);
      chk("postrst_out_pc", out_pc, 32'h0);
      chk("postrst_out_cause", {30'h0, out_cause}, 32'h0);
      chk("postrst_pc", pc, RV);
    end
    stray_ok = 1'b0;

    // Restart from the reset vector.
    push_req(RV, -1);
    push_out(32'h13, RV, 2'd0);
    out_ready = 1'b0;
    cycle();
    run = 1'b1;
    cycle();
    run = 1'b0;
    wait_out_valid("restart");
    repeat (3) @(negedge clk);
    chk("end_req_queue", 32'(exp_req.size()), 32'd0);
    chk("end_out_queue", 32'(exp_out.size()), 32'd1);
    chk("end_bus_queue", 32'(bus_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
